// File: rtl/rle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rle_sequencer
// Description : Arm/trigger/post-trigger sequencer that drives an RLE encoder
//               and issues the final run-count flush.
// Revision    : 1.0 - initial release
// ============================================================================
module rle_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             arm,
    input  logic             abort,
    input  logic             trigger,
    input  logic             cfg_rle,
    input  logic [3:0]       cfg_disabled_groups,
    input  logic [CNT_W-1:0] cfg_delay_count,
    input  logic             enc_valid_out,
    output logic             enc_enable,
    output logic [1:0]       enc_mode,
    output logic [31:0]      enc_data_mask,
    output logic             enc_flush,
    output logic             armed,
    output logic             triggered,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ARMED      = 3'd1,
        S_POST       = 3'd2,
        S_FLUSH      = 3'd3,
        S_WAIT_FLUSH = 3'd4,
        S_DONE       = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_rle;
    logic             w_rle_nxt;
    logic [3:0]       r_dis;
    logic [3:0]       w_dis_nxt;
    logic [CNT_W-1:0] r_delay;
    logic [CNT_W-1:0] w_delay_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [1:0]       r_wait;
    logic [1:0]       w_wait_nxt;
    logic [2:0]       w_n_enabled;
    logic [1:0]       w_mode_nxt;
    logic [31:0]      w_mask_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_rle_nxt   = r_rle;
        w_dis_nxt   = r_dis;
        w_delay_nxt = r_delay;
        w_cnt_nxt   = r_cnt;
        w_wait_nxt  = r_wait;
        if (abort) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_wait_nxt  = 2'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        w_rle_nxt   = cfg_rle;
                        w_dis_nxt   = cfg_disabled_groups;
                        w_delay_nxt = cfg_delay_count;
                        w_state_nxt = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (trigger) begin
                        w_cnt_nxt   = r_delay;
                        w_state_nxt = (r_delay != '0) ? S_POST : S_FLUSH;
                    end
                end
                S_POST: begin
                    // POST is only entered with a nonzero count, and leaves on reaching zero.
                    if (enc_valid_out && (r_cnt != '0)) begin
                        w_cnt_nxt = r_cnt - 1'b1;
                        if (r_cnt == CNT_W'(1)) begin
                            w_state_nxt = S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    w_wait_nxt  = 2'd0;
                    w_state_nxt = r_rle ? S_WAIT_FLUSH : S_DONE;
                end
                S_WAIT_FLUSH: begin
                    if (enc_valid_out || (r_wait == 2'd3)) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_wait_nxt = r_wait + 2'd1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Zero enabled groups is treated like all four: full 32-bit packing.
    always_comb begin
        w_n_enabled = 3'd4 - 3'(w_dis_nxt[0]) - 3'(w_dis_nxt[1])
                           - 3'(w_dis_nxt[2]) - 3'(w_dis_nxt[3]);
        case (w_n_enabled)
            3'd1:    w_mode_nxt = 2'd0;
            3'd2:    w_mode_nxt = 2'd1;
            3'd3:    w_mode_nxt = 2'd2;
            default: w_mode_nxt = 2'd3;
        endcase
        case (w_mode_nxt)
            2'd0:    w_mask_nxt = 32'h0000_00FF;
            2'd1:    w_mask_nxt = 32'h0000_FFFF;
            2'd2:    w_mask_nxt = 32'h00FF_FFFF;
            default: w_mask_nxt = 32'hFFFF_FFFF;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_rle         <= 1'b0;
            r_dis         <= 4'd0;
            r_delay       <= '0;
            r_cnt         <= '0;
            r_wait        <= 2'd0;
            enc_enable    <= 1'b0;
            enc_mode      <= 2'd3;
            enc_data_mask <= 32'hFFFF_FFFF;
            enc_flush     <= 1'b0;
            armed         <= 1'b0;
            triggered     <= 1'b0;
            done          <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_rle         <= w_rle_nxt;
            r_dis         <= w_dis_nxt;
            r_delay       <= w_delay_nxt;
            r_cnt         <= w_cnt_nxt;
            r_wait        <= w_wait_nxt;
            enc_enable    <= w_rle_nxt && (w_state_nxt inside {S_ARMED, S_POST, S_FLUSH, S_WAIT_FLUSH});
            enc_mode      <= w_mode_nxt;
            enc_data_mask <= w_mask_nxt;
            enc_flush     <= w_rle_nxt && (w_state_nxt == S_FLUSH);
            armed         <= (w_state_nxt == S_ARMED);
            triggered     <= (w_state_nxt inside {S_POST, S_FLUSH, S_WAIT_FLUSH});
            done          <= (w_state_nxt == S_DONE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rle_sequencer
// Description : Directed and random stimulus for rle_sequencer against a
//               cycle-level reference model of the sequencing rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rle_sequencer;

    localparam int CNT_W = 16;

    localparam int P_IDLE  = 0;
    localparam int P_WAITT = 1;
    localparam int P_COUNT = 2;
    localparam int P_FLUSH = 3;
    localparam int P_DRAIN = 4;
    localparam int P_DONE  = 5;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             arm;
    logic             abort;
    logic             trigger;
    logic             cfg_rle;
    logic [3:0]       cfg_disabled_groups;
    logic [CNT_W-1:0] cfg_delay_count;
    logic             enc_valid_out;
    logic             enc_enable;
    logic [1:0]       enc_mode;
    logic [31:0]      enc_data_mask;
    logic             enc_flush;
    logic             armed;
    logic             triggered;
    logic             done;

    int checks = 0;
    int errors = 0;
    int flushes = 0;

    // Reference model: phase, latched config, words still expected, drain cycles.
    int          m_ph;
    logic        m_rle;
    logic [3:0]  m_dis;
    int          m_delay;
    int          m_left;
    int          m_drain;

    rle_sequencer #(.CNT_W(CNT_W)) dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .arm                 (arm),
        .abort               (abort),
        .trigger             (trigger),
        .cfg_rle             (cfg_rle),
        .cfg_disabled_groups (cfg_disabled_groups),
        .cfg_delay_count     (cfg_delay_count),
        .enc_valid_out       (enc_valid_out),
        .enc_enable          (enc_enable),
        .enc_mode            (enc_mode),
        .enc_data_mask       (enc_data_mask),
        .enc_flush           (enc_flush),
        .armed               (armed),
        .triggered           (triggered),
        .done                (done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int exp_mode();
        int n;
        n = 4 - $countones(m_dis);
        return (n == 0 || n == 4) ? 3 : n - 1;
    endfunction

    function automatic logic [31:0] exp_mask();
        logic [63:0] full;
        full = (64'd1 << (8 * (exp_mode() + 1))) - 64'd1;
        return full[31:0];
    endfunction

    task automatic model_reset();
        m_ph = P_IDLE; m_rle = 1'b0; m_dis = 4'd0; m_delay = 0; m_left = 0; m_drain = 0;
    endtask

    task automatic model_step(input logic a, input logic ab, input logic tr, input logic v);
        if (ab) begin
            m_ph = P_IDLE;
            m_left = 0;
        end else if (m_ph == P_IDLE || m_ph == P_DONE) begin
            if (a) begin
                m_rle = cfg_rle; m_dis = cfg_disabled_groups; m_delay = int'(cfg_delay_count);
                m_ph = P_WAITT;
            end
        end else if (m_ph == P_WAITT) begin
            if (tr) begin
                m_left = m_delay;
                m_ph = (m_delay > 0) ? P_COUNT : P_FLUSH;
            end
        end else if (m_ph == P_COUNT) begin
            if (v) begin
                m_left = m_left - 1;
                if (m_left == 0) m_ph = P_FLUSH;
            end
        end else if (m_ph == P_FLUSH) begin
            m_drain = 0;
            m_ph = m_rle ? P_DRAIN : P_DONE;
        end else if (m_ph == P_DRAIN) begin
            m_drain = m_drain + 1;
            if (v || m_drain == 4) m_ph = P_DONE;
        end
    endtask

    task automatic check_all(input string tag);
        logic active;
        active = (m_ph == P_WAITT || m_ph == P_COUNT || m_ph == P_FLUSH || m_ph == P_DRAIN);
        chk({tag, ".enable"},    32'(enc_enable),    32'(m_rle && active));
        chk({tag, ".mode"},      32'(enc_mode),      32'(exp_mode()));
        chk({tag, ".mask"},      enc_data_mask,      exp_mask());
        chk({tag, ".flush"},     32'(enc_flush),     32'(m_rle && m_ph == P_FLUSH));
        chk({tag, ".armed"},     32'(armed),         32'(m_ph == P_WAITT));
        chk({tag, ".triggered"}, 32'(triggered),     32'(m_ph == P_COUNT || m_ph == P_FLUSH || m_ph == P_DRAIN));
        chk({tag, ".done"},      32'(done),          32'(m_ph == P_DONE));
        if (enc_flush === 1'b1) flushes++;
    endtask

    task automatic set_cfg(input logic r, input logic [3:0] d, input int dl);
        cfg_rle = r; cfg_disabled_groups = d; cfg_delay_count = CNT_W'(dl);
    endtask

    task automatic cyc(input string tag, input logic a, input logic ab, input logic tr, input logic v);
        @(negedge clock);
        arm = a; abort = ab; trigger = tr; enc_valid_out = v;
        @(posedge clock);
        model_step(a, ab, tr, v);
        #1;
        check_all(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".enable"},    32'(enc_enable), 32'd0);
        chk({tag, ".flush"},     32'(enc_flush),  32'd0);
        chk({tag, ".armed"},     32'(armed),      32'd0);
        chk({tag, ".triggered"}, 32'(triggered),  32'd0);
        chk({tag, ".done"},      32'(done),       32'd0);
        chk({tag, ".mode"},      32'(enc_mode),   32'd3);
        chk({tag, ".mask"},      enc_data_mask,   32'hFFFF_FFFF);
    endtask

    initial begin
        reset_n = 1'b0; arm = 1'b0; abort = 1'b0; trigger = 1'b0; enc_valid_out = 1'b0;
        set_cfg(1'b0, 4'd0, 0);
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(negedge clock);
        reset_n = 1'b1;
        cyc("post_reset", 0, 0, 0, 0);

        // Case 1: three groups, RLE on, 8 words after trigger.
        set_cfg(1'b1, 4'b1000, 8);
        cyc("c1_arm", 1, 0, 0, 0);
        chk("c1_mode", 32'(enc_mode), 32'd2);
        chk("c1_mask", enc_data_mask, 32'h00FF_FFFF);
        chk("c1_enable", 32'(enc_enable), 32'd1);
        flushes = 0;
        cyc("c1_trig", 0, 0, 1, 1);
        for (int i = 0; i < 8; i++) cyc("c1_post", 0, 0, 0, 1);
        chk("c1_flush_after_8", 32'(enc_flush), 32'd1);
        cyc("c1_wait", 0, 0, 0, 0);
        cyc("c1_drain", 0, 0, 0, 1);
        chk("c1_done", 32'(done), 32'd1);
        chk("c1_flush_count", 32'(flushes), 32'd1);

        // Case 2: one group, zero delay, drain by timeout; arm restarts from DONE.
        set_cfg(1'b1, 4'b1011, 0);
        cyc("c2_arm", 1, 0, 0, 0);
        chk("c2_mode", 32'(enc_mode), 32'd0);
        chk("c2_mask", enc_data_mask, 32'h0000_00FF);
        cyc("c2_trig", 0, 0, 1, 0);
        chk("c2_flush", 32'(enc_flush), 32'd1);
        for (int i = 0; i < 4; i++) cyc("c2_wait", 0, 0, 0, 0);
        chk("c2_not_done_yet", 32'(done), 32'd0);
        cyc("c2_timeout", 0, 0, 0, 0);
        chk("c2_done", 32'(done), 32'd1);

        // Case 3: RLE off, no flush, done right after FLUSH.
        set_cfg(1'b0, 4'b0000, 3);
        flushes = 0;
        cyc("c3_arm", 1, 0, 0, 0);
        cyc("c3_trig", 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc("c3_post", 0, 0, 0, 1);
        cyc("c3_after_flush", 0, 0, 0, 0);
        chk("c3_done", 32'(done), 32'd1);
        chk("c3_no_flush", 32'(flushes), 32'd0);

        // Case 4: abort in POST with five words left, coincident with arm and trigger.
        set_cfg(1'b1, 4'b0000, 7);
        flushes = 0;
        cyc("c4_arm", 1, 0, 0, 0);
        cyc("c4_trig", 0, 0, 1, 0);
        cyc("c4_post", 0, 0, 0, 1);
        cyc("c4_post", 0, 0, 0, 1);
        cyc("c4_abort_arm", 1, 1, 0, 1);
        chk("c4_idle_a", 32'({armed, triggered, done}), 32'd0);
        cyc("c4_arm2", 1, 0, 0, 0);
        cyc("c4_trig2", 0, 0, 1, 0);
        cyc("c4_post2", 0, 0, 0, 1);
        cyc("c4_post2", 0, 0, 0, 1);
        cyc("c4_abort_trig", 0, 1, 1, 0);
        chk("c4_idle_b", 32'({armed, triggered, done}), 32'd0);
        cyc("c4_abort_arm_idle", 1, 1, 0, 0);
        chk("c4_stay_idle", 32'(armed), 32'd0);
        chk("c4_no_flush", 32'(flushes), 32'd0);

        // Case 5: ignored trigger/arm/config, then async reset in WAIT_FLUSH.
        cyc("c5_trig_idle", 0, 0, 1, 0);
        chk("c5_trig_ignored", 32'(armed | triggered), 32'd0);
        set_cfg(1'b1, 4'b0001, 2);
        cyc("c5_arm", 1, 0, 0, 0);
        set_cfg(1'b0, 4'b0111, 9);
        cyc("c5_arm_again", 1, 0, 0, 0);
        chk("c5_mode_kept", 32'(enc_mode), 32'd2);
        cyc("c5_trig", 0, 0, 1, 0);
        cyc("c5_post", 0, 0, 0, 1);
        cyc("c5_post", 0, 0, 0, 1);
        chk("c5_flush_latched_cfg", 32'(enc_flush), 32'd1);
        cyc("c5_wait", 0, 0, 0, 0);
        @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_reset_outputs("c5_async_reset");
        @(negedge clock);
        reset_n = 1'b1;
        cyc("c5_after_reset", 0, 0, 0, 0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            set_cfg(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), int'($urandom_range(0, 5)));
            cyc("rand",
                1'($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 24) == 0),
                1'($urandom_range(0, 5) == 0),
                1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
